// File: rtl/alu_seq_if.sv
// Request/response handshake bundle for alu_seq_exec: operation request in, result out.
interface alu_seq_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      alu_ctrl;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;

  modport master (
    output in_valid, alu_ctrl, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, zero
  );
  modport slave (
    input  in_valid, alu_ctrl, op_a, op_b, out_ready,
    output in_ready, out_valid, result, zero
  );
endinterface

// File: rtl/alu_seq_exec.sv
// EX-stage ALU: one op per valid/ready transaction; shifts iterate one bit per cycle
// unless ALU_SEQ_BARREL_SHIFT_EN is defined, which makes every op single-cycle.
module alu_seq_exec #(
  parameter int XLEN = 32
) (
  input  logic      clk,
  input  logic      rst_n,
  alu_seq_if.slave  bus
);
  localparam int SHAMT_W = $clog2(XLEN);

  localparam logic [3:0] ADD  = 4'b0000, SUB = 4'b0001, SLL = 4'b0010, SLT  = 4'b0011,
                         SLTU = 4'b0100, XOR = 4'b0101, SRL = 4'b0110, SRA  = 4'b0111,
                         OR   = 4'b1000, AND = 4'b1001, LUI = 4'b1010;

`ifdef ALU_SEQ_BARREL_SHIFT_EN
  typedef enum logic [1:0] {IDLE, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

  state_t state;

  function automatic logic [XLEN-1:0] alu_comb(input logic [3:0] c,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
    logic [XLEN-1:0] r;
`ifdef ALU_SEQ_BARREL_SHIFT_EN
    logic [SHAMT_W-1:0] sh;
    sh = b[SHAMT_W-1:0];
`endif
    r = '0;
    case (c)
      ADD:  r = a + b;
      SUB:  r = a - b;
      SLT:  r = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      SLTU: r = {{(XLEN-1){1'b0}}, (a < b)};
      XOR:  r = a ^ b;
      OR:   r = a | b;
      AND:  r = a & b;
      LUI:  r = b;
`ifdef ALU_SEQ_BARREL_SHIFT_EN
      SLL:  r = a << sh;
      SRL:  r = a >> sh;
      SRA:  r = XLEN'($signed(a) >>> sh);
`else
      // only reached with shamt==0; nonzero shifts go through SHIFT
      SLL, SRL, SRA: r = a;
`endif
      default: r = '0;
    endcase
    return r;
  endfunction

  logic [XLEN-1:0] alu_res;
  assign alu_res = alu_comb(bus.alu_ctrl, bus.op_a, bus.op_b);

`ifndef ALU_SEQ_BARREL_SHIFT_EN
  logic [3:0]         op_ctrl;
  logic [XLEN-1:0]    acc;
  logic [XLEN-1:0]    acc_next;
  logic [SHAMT_W-1:0] cnt;
  logic [SHAMT_W-1:0] shamt_in;
  logic               is_shift;

  assign shamt_in = bus.op_b[SHAMT_W-1:0];
  assign is_shift = (bus.alu_ctrl == SLL) || (bus.alu_ctrl == SRL) || (bus.alu_ctrl == SRA);

  always_comb begin
    acc_next = acc;
    case (op_ctrl)
      SLL:     acc_next = acc << 1;
      SRL:     acc_next = acc >> 1;
      default: acc_next = {acc[XLEN-1], acc[XLEN-1:1]};
    endcase
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.result    <= '0;
      bus.zero      <= 1'b1;
`ifndef ALU_SEQ_BARREL_SHIFT_EN
      op_ctrl       <= '0;
      acc           <= '0;
      cnt           <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (bus.in_valid && bus.in_ready) begin
          bus.in_ready <= 1'b0;
`ifndef ALU_SEQ_BARREL_SHIFT_EN
          if (is_shift && (shamt_in != '0)) begin
            state   <= SHIFT;
            op_ctrl <= bus.alu_ctrl;
            acc     <= bus.op_a;
            cnt     <= shamt_in;
          end else
`endif
          begin
            state         <= DONE;
            bus.out_valid <= 1'b1;
            bus.result    <= alu_res;
            bus.zero      <= (alu_res == '0);
          end
        end
`ifndef ALU_SEQ_BARREL_SHIFT_EN
        SHIFT: begin
          acc <= acc_next;
          cnt <= cnt - SHAMT_W'(1);
          if (cnt == SHAMT_W'(1)) begin
            state         <= DONE;
            bus.out_valid <= 1'b1;
            bus.result    <= acc_next;
            bus.zero      <= (acc_next == '0);
          end
        end
`endif
        DONE: if (bus.out_ready) begin
          state         <= IDLE;
          bus.out_valid <= 1'b0;
          bus.in_ready  <= 1'b1;
        end
        default: begin
          state         <= IDLE;
          bus.in_ready  <= 1'b1;
          bus.out_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq_exec.sv
// Directed vector bench for alu_seq_exec: table of ops plus backpressure and reset sequences.
module tb_alu_seq_exec;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  alu_seq_if #(.XLEN(32)) bus ();
  alu_seq_exec #(.XLEN(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [3:0] c, input logic [31:0] b);
`ifdef ALU_SEQ_BARREL_SHIFT_EN
    return 1;
`else
    if ((c == 4'b0010 || c == 4'b0110 || c == 4'b0111) && b[4:0] != 5'd0)
      return 1 + int'(b[4:0]);
    return 1;
`endif
  endfunction

  task automatic do_op(input string name, input vec_t v);
    int lat;
    bit busy_ok;
    @(negedge clk);
    check({name, "/ready_idle"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.alu_ctrl = v.ctrl;
    bus.op_a     = v.a;
    bus.op_b     = v.b;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.op_a     = $urandom;
    bus.op_b     = $urandom;
    bus.alu_ctrl = 4'($urandom);
    lat = 1;
    busy_ok = 1'b1;
    while (!bus.out_valid && lat < 100) begin
      if (bus.in_ready) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (bus.in_ready) busy_ok = 1'b0;
    check({name, "/latency"}, 32'(lat), 32'(exp_lat(v.ctrl, v.b)));
    check({name, "/result"}, bus.result, v.res);
    check({name, "/zero"}, 32'(bus.zero), 32'(v.z));
    check({name, "/busy"}, 32'(busy_ok), 32'd1);
    @(posedge clk); #1;
    check({name, "/back_idle"}, {30'd0, bus.out_valid, bus.in_ready}, 32'b01);
  endtask

  initial begin
    vecs[0]  = '{4'b0000, 32'd5,          32'd7,          32'd12,         1'b0}; // ADD
    vecs[1]  = '{4'b0001, 32'd3,          32'd5,          32'hFFFFFFFE,   1'b0}; // SUB
    vecs[2]  = '{4'b0001, 32'd9,          32'd9,          32'd0,          1'b1}; // SUB zero
    vecs[3]  = '{4'b0111, 32'h80000000,   32'd4,          32'hF8000000,   1'b0}; // SRA
    vecs[4]  = '{4'b0011, 32'hFFFFFFFF,   32'd1,          32'd1,          1'b0}; // SLT
    vecs[5]  = '{4'b0100, 32'hFFFFFFFF,   32'd1,          32'd0,          1'b1}; // SLTU
    vecs[6]  = '{4'b1010, 32'hDEADBEEF,   32'h12345000,   32'h12345000,   1'b0}; // LUI
    vecs[7]  = '{4'b0101, 32'h0000F0F0,   32'h0000FF00,   32'h00000FF0,   1'b0}; // XOR
    vecs[8]  = '{4'b1000, 32'hA0000005,   32'h0A000050,   32'hAA000055,   1'b0}; // OR
    vecs[9]  = '{4'b1001, 32'hF0F0F0F0,   32'h0F0F0F0F,   32'd0,          1'b1}; // AND
    vecs[10] = '{4'b0110, 32'h80000000,   32'd31,         32'd1,          1'b0}; // SRL max
    vecs[11] = '{4'b0010, 32'd1,          32'hFFFFFF23,   32'd8,          1'b0}; // SLL shamt=3
    vecs[12] = '{4'b1011, 32'd123,        32'd456,        32'd0,          1'b1}; // undefined
    vecs[13] = '{4'b0111, 32'h40000000,   32'd1,          32'h20000000,   1'b0}; // SRA positive
    vecs[14] = '{4'b0011, 32'd1,          32'hFFFFFFFF,   32'd0,          1'b1}; // SLT 1 < -1 false
    vecs[15] = '{4'b0000, 32'hFFFFFFFF,   32'd1,          32'd0,          1'b1}; // ADD wrap
    vecs[16] = '{4'b0010, 32'h80000001,   32'd1,          32'h00000002,   1'b0}; // SLL drop MSB

    bus.in_valid  = 1'b0;
    bus.alu_ctrl  = 4'd0;
    bus.op_a      = 32'd0;
    bus.op_b      = 32'd0;
    bus.out_ready = 1'b1;

    #12;
    check("reset/in_ready",  32'(bus.in_ready),  32'd1);
    check("reset/out_valid", 32'(bus.out_valid), 32'd0);
    check("reset/result",    bus.result,         32'd0);
    check("reset/zero",      32'(bus.zero),      32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) do_op($sformatf("vec%0d", i), vecs[i]);

    // backpressure on a zero-amount shift; a second request while busy must be dropped
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.alu_ctrl  = 4'b0010;
    bus.op_a      = 32'd1;
    bus.op_b      = 32'd0;
    @(posedge clk); #1;
    check("bp/first_valid", 32'(bus.out_valid), 32'd1);
    check("bp/first_result", bus.result, 32'd1);
    bus.alu_ctrl = 4'b0000;
    bus.op_a     = 32'd100;
    bus.op_b     = 32'd100;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("bp/hold%0d", k),
            {bus.out_valid, bus.in_ready, bus.zero, bus.result[28:0]}, {3'b100, 29'd1});
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp/idle", {30'd0, bus.out_valid, bus.in_ready}, 32'b01);
    @(posedge clk); #1;
    check("bp/not_queued", 32'(bus.out_valid), 32'd0);

    // async reset during a long shift
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.alu_ctrl = 4'b0010;
    bus.op_a     = 32'd1;
    bus.op_b     = 32'd31;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (11) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst/out_valid", 32'(bus.out_valid), 32'd0);
    check("rst/result",    bus.result,         32'd0);
    check("rst/in_ready",  32'(bus.in_ready),  32'd1);
    check("rst/zero",      32'(bus.zero),      32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    do_op("post_rst_add", '{4'b0000, 32'd1, 32'd1, 32'd2, 1'b0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
